// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic two-entry pipeline register between pipeline stages.
// Ports: clk, clr (async, active-high), flush, in_valid/in_ready/in_data
//        (upstream), out_valid/out_ready/out_data (downstream).
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // State bits are {main_v, skid_v}; 2'b01 has no encoding on purpose.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] main_nx;
    logic [WIDTH-1:0] skid_nx;
    logic             main_v;
    logic             skid_v;
    logic             accept;
    logic             consume;

    assign main_v    = state[1];
    assign skid_v    = state[0];

    // Ready comes straight from the skid flop: no path from out_ready.
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;

    assign accept    = in_valid & in_ready;
    assign consume   = main_v & out_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= EMPTY;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            state  <= state_nx;
            main_d <= main_nx;
            skid_d <= skid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        main_nx  = main_d;
        skid_nx  = skid_d;
        if (flush) begin
            // Squash wins over any accept/consume; data may stay stale.
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nx = ONE;
                        main_nx  = in_data;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_nx  = in_data;
                    end else if (accept) begin
                        state_nx = TWO;
                        skid_nx  = in_data;
                    end else if (consume) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (consume) begin
                        state_nx = ONE;
                        main_nx  = skid_d;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                end
            endcase
        end
    end

    a_no_skid_only: assert property (
        @(posedge clk) disable iff (clr)
        !(skid_v && !main_v)
    );

    a_stall_stable: assert property (
        @(posedge clk) disable iff (clr)
        (out_valid && !out_ready && !flush)
        |=> (out_valid && $stable(out_data))
    );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline register between two MIPS pipeline stages, e.g. IF/ID or ID/EX.
- Upstream stage writes through a valid/ready handshake; downstream stage reads through its own valid/ready handshake.
- A two-entry skid buffer gives full throughput with registered backpressure, so there is no combinational ready path through the stage.
- A synchronous flush squashes in-flight instructions on branch or exception.

Parameters:
- WIDTH, 32, payload width in bits (instruction/PC bundle).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  upstream has a payload on in_data.
- in_ready  output  1  stage can accept; driven directly from a flop, no combinational input path.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  WIDTH  payload presented to the downstream stage.

Behaviour:
- Storage:
  - main register (main_v, main_d) drives out_valid and out_data.
  - skid register (skid_v, skid_d) holds overflow.
  - in_ready = ~skid_v.
- Handshakes:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Consume occurs when out_valid & out_ready at a rising edge.
- Reset (clr=1, asynchronous, takes effect immediately without waiting for a clock edge):
  - main_v=0, skid_v=0, main_d=0, skid_d=0.
  - Outputs: out_valid=0, out_data=0, in_ready=1.
  - Reset mid-transfer discards all entries; no partial payload survives.
- States (main_v, skid_v):
  - EMPTY (0,0)
  - ONE (1,0)
  - TWO (1,1)
  - (0,1) is illegal and unreachable.
- Transitions per edge, with flush=0:
  - EMPTY, accept -> ONE; main_d<=in_data.
  - ONE, accept & consume -> ONE; main_d<=in_data.
  - ONE, accept & ~consume -> TWO; skid_d<=in_data, main_d unchanged.
  - ONE, consume & ~accept -> EMPTY.
  - TWO, consume -> ONE; main_d<=skid_d. No accept is possible because in_ready=0.
  - All other cases hold state and data.
- Latency and ordering:
  - A payload accepted at edge N is visible on out_data after edge N, i.e. 1-cycle latency from EMPTY.
  - Order is strictly FIFO; payloads are never dropped or duplicated.
  - Sustained throughput is one payload per cycle while out_ready=1.
- Flush:
  - At the edge with flush=1: main_v<=0 and skid_v<=0, overriding any accept or consume in the same cycle.
  - A payload presented with flush is not accepted. The upstream sees in_ready as high, so the upstream must itself squash on flush.
  - Data registers may hold stale values after flush; out_data is don't-care when out_valid=0.
- Data rules:
  - out_data changes only on load of main.
  - While out_valid=1 & out_ready=0, out_data and out_valid stay stable.
- Assertions:
  - The state (0,1) never occurs.
  - in_ready never depends combinationally on out_ready.

Test Plan:
- Reset: assert clr asynchronously between edges -> out_valid=0, out_data=0, in_ready=1 immediately; release, no activity -> state unchanged.
- Streaming: in_valid=1, out_ready=1, in_data=0x10,0x11,0x12,0x13 on consecutive cycles -> out_data 0x10..0x13 one cycle later each, out_valid continuous, in_ready=1 throughout.
- Backpressure: with out_ready=0, accept 0xA0 then 0xA1 -> out_data=0xA0, in_ready=0 after second accept, 0xA2 held off. Then out_ready=1 -> 0xA0, 0xA1, 0xA2 appear in order with no loss.
- Stall stability: TWO state with out_ready=0 for 5 cycles -> out_data=0xA0 and out_valid=1 unchanged, in_ready=0.
- Flush: in TWO state, assert flush together with out_ready=1 and in_valid=1 (0xFF) -> next cycle out_valid=0, in_ready=1, 0xFF never appears.
- Random: randomised in_valid/out_ready for 10k cycles against a scoreboard queue -> zero ordering mismatches, no drops, illegal state never reached.
